// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX frame serializer.
package uart_tx_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN    = 1'b0;
    localparam logic PAR_ODD     = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Line cycles for one frame: start + payload + optional parity + stop bits
    function automatic int unsigned frame_len(input int unsigned data_width,
                                              input int unsigned stop_bits,
                                              input int unsigned par);
        return 1 + data_width + par + stop_bits;
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce of the payload, inverted for odd parity.
module uart_parity_calc #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // par_typ = 1 selects odd parity
    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART TX frame serializer: sequences start, data (LSB first), optional parity and
// stop bits onto a registered serial line, one bit per baud clock.
module uart_tx_frame_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned PARITY_SUPPORT = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DATA_VALID,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  ACCEPT
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastData = CntW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0] LastStop = CntW'(STOP_BITS - 1);

    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame_serializer: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_tx_frame_serializer: DATA_WIDTH must be 5..9");
    end

    tx_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  par_calc;
    logic                  par_en_in;
    logic                  accept;

    // Parity stage exists only when supported; otherwise parity is never enabled
    if (PARITY_SUPPORT != 0) begin : g_parity
        uart_parity_calc #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_parity_calc (
            .data    (P_DATA),
            .par_typ (PAR_TYP),
            .par_bit (par_calc)
        );
        assign par_en_in = PAR_EN;
    end else begin : g_no_parity
        assign par_calc  = 1'b0;
        assign par_en_in = 1'b0;
    end

    // Next-state: frame sequencing, input capture on accept
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        accept    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (DATA_VALID && !RST) begin
                    accept  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == LastData) begin
                    state_d = par_en_q ? StParity : StStop;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                state_d = StStop;
                cnt_d   = '0;
            end
            StStop: begin
                if (cnt_q == LastStop) begin
                    cnt_d = '0;
                    // Accepting on the last stop bit chains the next frame with no gap
                    if (DATA_VALID && !RST) begin
                        accept  = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            shadow_d  = P_DATA;
            par_en_d  = par_en_in;
            par_bit_d = par_calc;
        end
    end

    // Output select from the next state, so the line register lines up with the state
    always_comb begin
        tx_d   = IDLE_LEVEL;
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StStart:  tx_d = START_LEVEL;
            StData:   tx_d = shadow_d[cnt_d];
            StParity: tx_d = par_bit_d;
            default:  tx_d = IDLE_LEVEL;
        endcase
    end

    // State and line registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shadow_q  <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;
    assign ACCEPT = accept;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Bench for uart_tx_frame_serializer: a 1-stop and a 2-stop build share the same stimulus
// and are compared every cycle against a frame-level line model.
module tb_uart_tx_frame_serializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       DATA_VALID = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       tx0, busy0, acc0;
    logic       tx1, busy1, acc1;

    int checks = 0;
    int errors = 0;

    // Model: bits still to appear on each line after the current one
    logic [15:0] pend_v [2];
    int          pend_n [2];
    logic        m_line [2];
    logic        m_busy [2];
    int          acc_cnt0;
    int          busy_cnt0;
    logic        busy_min0;
    logic [10:0] cap;

    always #5 CLK = ~CLK;

    uart_tx_frame_serializer #(
        .DATA_WIDTH     (8),
        .STOP_BITS      (1),
        .PARITY_SUPPORT (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_VALID (DATA_VALID),
        .P_DATA     (P_DATA),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (tx0),
        .BUSY       (busy0),
        .ACCEPT     (acc0)
    );

    uart_tx_frame_serializer #(
        .DATA_WIDTH     (8),
        .STOP_BITS      (2),
        .PARITY_SUPPORT (1)
    ) dut2 (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_VALID (DATA_VALID),
        .P_DATA     (P_DATA),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (tx1),
        .BUSY       (busy1),
        .ACCEPT     (acc1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bit sequence of one frame, element 0 first on the line
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic pe,
                                               input logic pt, input int sb,
                                               output int len);
        logic [15:0] f;
        int n;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        n = 9;
        if (pe) begin
            f[n] = (^d) ^ pt;
            n++;
        end
        len = n + sb;
        return f;
    endfunction

    // One baud cycle: check ACCEPT before the edge, advance model, check line after it
    task automatic tick();
        logic acc_e [2];
        logic [15:0] f;
        int len;
        #1;
        for (int i = 0; i < 2; i++) acc_e[i] = DATA_VALID && !RST && (pend_n[i] == 0);
        check("accept_1stop", 32'(acc0), 32'(acc_e[0]));
        check("accept_2stop", 32'(acc1), 32'(acc_e[1]));
        if (acc0) acc_cnt0++;
        @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_line[i] = 1'b1;
                m_busy[i] = 1'b0;
                pend_n[i] = 0;
            end else if (acc_e[i]) begin
                f = frame_bits(P_DATA, PAR_EN, PAR_TYP, i + 1, len);
                m_line[i] = f[0];
                pend_v[i] = f >> 1;
                pend_n[i] = len - 1;
                m_busy[i] = 1'b1;
            end else if (pend_n[i] > 0) begin
                m_line[i] = pend_v[i][0];
                pend_v[i] = pend_v[i] >> 1;
                pend_n[i]--;
                m_busy[i] = 1'b1;
            end else begin
                m_line[i] = 1'b1;
                m_busy[i] = 1'b0;
            end
        end
        @(negedge CLK);
        check("tx_1stop", 32'(tx0), 32'(m_line[0]));
        check("busy_1stop", 32'(busy0), 32'(m_busy[0]));
        check("tx_2stop", 32'(tx1), 32'(m_line[1]));
        check("busy_2stop", 32'(busy1), 32'(m_busy[1]));
        if (busy0) busy_cnt0++;
        if (!busy0) busy_min0 = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        DATA_VALID = 1'b1;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        tick();
        DATA_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pend_n[i] = 0;
            pend_v[i] = '0;
            m_line[i] = 1'b1;
            m_busy[i] = 1'b0;
        end

        // Reset held with DATA_VALID high: nothing may be accepted
        RST = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA = 8'h5A;
        idle(3);
        RST = 1'b0;
        DATA_VALID = 1'b0;
        idle(3);
        check("idle_line_after_reset", 32'(tx0), 32'd1);

        // 0xA5 even parity on the 1-stop build
        acc_cnt0 = 0;
        busy_cnt0 = 0;
        send(8'hA5, 1'b1, 1'b0);
        cap[0] = tx0;
        for (int i = 1; i < 11; i++) begin
            tick();
            cap[i] = tx0;
        end
        idle(3);
        check("a5_frame_bits", 32'(cap), 32'(11'b10101001010));
        check("a5_busy_cycles", 32'(busy_cnt0), 32'd11);
        check("a5_line_idle_after", 32'(tx0), 32'd1);
        idle(4);

        // 0x0F without parity on the 2-stop build
        send(8'h0F, 1'b0, 1'b0);
        cap[0] = tx1;
        for (int i = 1; i < 11; i++) begin
            tick();
            cap[i] = tx1;
        end
        check("0f_2stop_frame_bits", 32'(cap), 32'(11'b11000011110));
        idle(6);

        // Back-to-back: 0xFF offered on the final stop cycle of the 0x01 frame
        acc_cnt0 = 0;
        busy_min0 = 1'b1;
        send(8'h01, 1'b1, 1'b1);
        idle(10);
        send(8'hFF, 1'b1, 1'b1);
        check("b2b_start_follows_stop", 32'(tx0), 32'd0);
        for (int i = 1; i < 11; i++) begin
            tick();
            cap[i] = tx0;
        end
        check("b2b_busy_no_dip", 32'(busy_min0), 32'd1);
        check("b2b_accept_pulses", 32'(acc_cnt0), 32'd2);
        check("ff_odd_parity_bit", 32'(cap[9]), 32'd1);
        idle(6);

        // Request during data bits is ignored
        acc_cnt0 = 0;
        send(8'h55, 1'b1, 1'b0);
        idle(3);
        DATA_VALID = 1'b1;
        P_DATA = 8'h3C;
        idle(3);
        DATA_VALID = 1'b0;
        idle(10);
        check("ignored_request_accepts", 32'(acc_cnt0), 32'd1);
        check("ignored_request_idle_line", 32'(tx0), 32'd1);
        check("ignored_request_idle_busy", 32'(busy0), 32'd0);

        // Reset during data bit 4 of 0xC3, then a clean 0x81 frame
        send(8'hC3, 1'b1, 1'b0);
        idle(5);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("reset_mid_frame_tx", 32'(tx0), 32'd1);
        check("reset_mid_frame_busy", 32'(busy0), 32'd0);
        send(8'h81, 1'b0, 1'b0);
        check("after_reset_start_bit", 32'(tx0), 32'd0);
        idle(14);

        // Randomised traffic including occasional resets
        for (int i = 0; i < 400; i++) begin
            DATA_VALID = ($urandom_range(2) == 0);
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            RST        = ($urandom_range(59) == 0);
            tick();
        end
        RST = 1'b0;
        DATA_VALID = 1'b0;
        idle(16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_serializer.md
Name: uart_tx_frame_serializer

Overview:
Parametrised successor to the UART TX registered output mux. It contains its own frame FSM, which sequences start, data, optional parity and 1-2 stop bits onto a single registered line, one bit per CLK cycle. It sits at the TX output stage and drives the serial pin directly. CLK is the baud-rate clock.

Parameters:
DATA_WIDTH, 8, number of payload bits per frame (5..9), sent LSB first.
STOP_BITS, 1, number of stop bits (1 or 2); any other value is a configuration error.
PARITY_SUPPORT, 1, 1 = parity stage present (runtime enable via PAR_EN); 0 = parity logic removed and PAR_EN ignored.

Ports:
CLK  input  1  baud clock; all logic is on the rising edge.
RST  input  1  synchronous reset, active-high.
DATA_VALID  input  1  request to send P_DATA; sampled only when the block can accept.
P_DATA  input  DATA_WIDTH  parallel payload, captured on accept.
PAR_EN  input  1  parity bit enable, captured on accept.
PAR_TYP  input  1  0 = even, 1 = odd, captured on accept.
TX_OUT  output  1  registered serial line, idle high.
BUSY  output  1  high while a frame is on the line.
ACCEPT  output  1  one-cycle pulse in the cycle P_DATA is captured (combinational from state and DATA_VALID).

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: TX_OUT=1, BUSY=0, state=IDLE, bit counter=0, shadow registers=0. Reset overrides everything, including mid-frame: on the next edge TX_OUT=1 and BUSY=0, and the partial frame is dropped.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: DATA_VALID=1 and (state==IDLE, or state==STOP on the final stop bit). On accept, P_DATA, PAR_EN and PAR_TYP are latched into shadow registers and the parity bit is computed.
- Parity bit: XOR-reduce(P_DATA) XOR PAR_TYP.
- DATA_VALID in any other cycle is ignored. Nothing is queued and ACCEPT stays 0.
- Transitions:
  - IDLE to START on accept.
  - START to DATA after 1 cycle.
  - DATA holds for DATA_WIDTH cycles, counter 0..DATA_WIDTH-1. Then it goes to PARITY if the latched PAR_EN is 1 (and PARITY_SUPPORT=1), otherwise to STOP.
  - PARITY to STOP after 1 cycle.
  - STOP holds for STOP_BITS cycles. Then it goes to START if an accept occurred on the last stop cycle, otherwise to IDLE.
- Output mux: the combinational select is START to 0, DATA to shadow[counter], PARITY to the parity bit, STOP/IDLE to 1. It is registered into TX_OUT.
- Latency: accept at edge n gives TX_OUT=0 (start) during cycle n+1. The final stop bit ends at cycle n+FRAME_LEN, where FRAME_LEN = 1 + DATA_WIDTH + PAR + STOP_BITS.
- BUSY is registered. It goes high in the same cycle as the start bit and stays high through the last stop bit. It goes low the following cycle unless back-to-back.
- Back-to-back frames: no idle cycle between the last stop bit and the next start bit, and BUSY stays 1 continuously.
- Counter width: clog2(DATA_WIDTH). It resets to 0 on entry to DATA and to STOP, so wrap-around never occurs.
- Input changes after accept have no effect on the frame in flight.

Decomposition:
- Shared package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding;
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - IDLE_LEVEL=1'b1 and START_LEVEL=1'b0;
  - FRAME_LEN function of the parameters.
- One natural sub-module, uart_parity_calc: parametrised DATA_WIDTH, purely combinational XOR-reduce with type select. It is instanced only when PARITY_SUPPORT=1.

Test Plan:
1. RST=1 for 3 cycles with DATA_VALID=1 -> TX_OUT=1, BUSY=0 and ACCEPT=0 throughout. After release, IDLE is held with TX_OUT=1.
2. Defaults; P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle DATA_VALID -> TX_OUT per cycle is 0,1,0,1,0,0,1,0,1,0,1 (11 bits). BUSY is high for exactly 11 cycles, then TX_OUT stays 1.
3. P_DATA=0x0F, PAR_EN=0, STOP_BITS=2 build -> TX_OUT is 0,1,1,1,1,0,0,0,0,1,1 (11 bits); no parity bit is present.
4. Back-to-back: send 0x01 with odd parity, then DATA_VALID=1 with 0xFF on the final stop cycle -> the 0xFF start bit immediately follows the stop bit, BUSY has no dip, and ACCEPT pulses twice. The 0xFF parity bit is 1 (odd).
5. DATA_VALID=1 with P_DATA=0x3C during DATA bits of a 0x55 frame -> the 0x55 frame is unchanged and ACCEPT=0. The line returns to IDLE afterwards with no second frame.
6. RST asserted on data bit 4 of 0xC3 -> next cycle TX_OUT=1 and BUSY=0. A following DATA_VALID with 0x81 produces a clean full frame starting with a start bit.
